// File: rtl/fft_writeback_sequencer.sv
// Copies a finished FFT result frame from the sample buffer to system memory,
// one buffer read followed by one Avalon-MM write per word.
module fft_writeback_sequencer #(
  parameter int NUM_POINTS  = 512,
  parameter int BUF_ADDR_W  = 9,
  parameter int DATA_W      = 16,
  parameter int BUS_ADDR_W  = 64,
  parameter int BYTE_STRIDE = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  fft_done,
  input  logic [BUS_ADDR_W-1:0] base_address,
  output logic                  sReEn,
  output logic [BUF_ADDR_W-1:0] sampled_address,
  input  logic [DATA_W-1:0]     sampled_data,
  output logic                  master_write,
  output logic [BUS_ADDR_W-1:0] master_address,
  output logic [DATA_W-1:0]     master_write_data,
  input  logic                  master_waitrequest,
  input  logic [1:0]            master_response,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LATCH  = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic [BUF_ADDR_W:0] LAST_IDX = (BUF_ADDR_W+1)'(NUM_POINTS - 1);
  localparam logic [BUF_ADDR_W:0] IDX_ONE  = (BUF_ADDR_W+1)'(1);

  state_t                  state_r, state_s;
  logic [BUF_ADDR_W:0]     idx_r, idx_s;
  logic [BUS_ADDR_W-1:0]   base_r;
  logic [BUS_ADDR_W-1:0]   offset_s;
  logic                    start_s;
  logic                    resp_err_s;
  logic                    accept_s;

  // Byte offset of the current word; the add below wraps modulo 2^BUS_ADDR_W.
  assign offset_s   = BUS_ADDR_W'(idx_r) * BUS_ADDR_W'(BYTE_STRIDE);
  assign resp_err_s = (master_response == 2'b10) || (master_response == 2'b11);
  assign accept_s   = (state_r == WRITE) && !master_waitrequest;

  // Next-state and word-index logic.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (fft_done) begin
          state_s = FETCH;
          idx_s   = '0;
          start_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH:  state_s = LATCH;
      LATCH:  state_s = WRITE;
      WRITE: begin
        if (!master_waitrequest) begin
          if (resp_err_s) begin
            state_s = FINISH;
          end else if (idx_r == LAST_IDX) begin
            state_s = FINISH;
          end else begin
            idx_s   = idx_r + IDX_ONE;
            state_s = FETCH;
          end
        end else begin
          state_s = WRITE;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, word index and latched base address.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
      idx_r   <= '0;
      base_r  <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      if (start_s) begin
        base_r <= base_address;
      end
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sReEn             <= 1'b0;
      sampled_address   <= '0;
      master_write      <= 1'b0;
      master_address    <= '0;
      master_write_data <= '0;
      busy              <= 1'b0;
      frame_done        <= 1'b0;
      error             <= 1'b0;
    end else begin
      sReEn        <= (state_s == FETCH);
      master_write <= (state_s == WRITE);
      busy         <= (state_s != IDLE);
      frame_done   <= (state_s == FINISH);
      if (state_s == FETCH) begin
        sampled_address <= idx_s[BUF_ADDR_W-1:0];
      end
      // Buffer data is valid in LATCH; address/data then stay frozen through WRITE.
      if (state_r == LATCH) begin
        master_write_data <= sampled_data;
        master_address    <= base_r + offset_s;
      end
      if (start_s) begin
        error <= 1'b0;
      end else if (accept_s && resp_err_s) begin
        error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fft_writeback_sequencer.sv
// Directed bench for fft_writeback_sequencer: a 4-point instance for the
// directed cases and a 512-point instance for the randomly stalled frame.
module tb_fft_writeback_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_rst;

  logic        fd_a, re_a, mw_a, wait_a, busy_a, fdone_a, err_a;
  logic [63:0] base_a, ma_a;
  logic [1:0]  addr_a, resp_a;
  logic [15:0] rd_a, md_a;

  logic        fd_b, re_b, mw_b, wait_b, busy_b, fdone_b, err_b;
  logic [63:0] base_b, ma_b;
  logic [8:0]  addr_b;
  logic [1:0]  resp_b;
  logic [15:0] rd_b, md_b;

  logic [15:0] buf_a [0:3];
  logic [15:0] buf_b [0:511];
  logic [15:0] img_b [0:511];
  logic [63:0] wq_addr_a [$];
  logic [15:0] wq_data_a [$];

  int recnt_b = 0;
  int wcnt_b  = 0;
  int overlap = 0;
  int unstable = 0;
  int compared = 0;
  int mismatched = 0;

  fft_writeback_sequencer #(.NUM_POINTS(4), .BUF_ADDR_W(2), .DATA_W(16),
                            .BUS_ADDR_W(64), .BYTE_STRIDE(2)) dut_a (
    .clk(clk), .n_rst(n_rst), .fft_done(fd_a), .base_address(base_a),
    .sReEn(re_a), .sampled_address(addr_a), .sampled_data(rd_a),
    .master_write(mw_a), .master_address(ma_a), .master_write_data(md_a),
    .master_waitrequest(wait_a), .master_response(resp_a),
    .busy(busy_a), .frame_done(fdone_a), .error(err_a));

  fft_writeback_sequencer #(.NUM_POINTS(512), .BUF_ADDR_W(9), .DATA_W(16),
                            .BUS_ADDR_W(64), .BYTE_STRIDE(2)) dut_b (
    .clk(clk), .n_rst(n_rst), .fft_done(fd_b), .base_address(base_b),
    .sReEn(re_b), .sampled_address(addr_b), .sampled_data(rd_b),
    .master_write(mw_b), .master_address(ma_b), .master_write_data(md_b),
    .master_waitrequest(wait_b), .master_response(resp_b),
    .busy(busy_b), .frame_done(fdone_b), .error(err_b));

  // Synchronous result buffers and the memory-side capture of accepted writes.
  always @(posedge clk) begin
    if (re_a) rd_a <= buf_a[addr_a];
    if (re_b) begin
      rd_b    <= buf_b[addr_b];
      recnt_b <= recnt_b + 1;
    end
    if (mw_a && !wait_a) begin
      wq_addr_a.push_back(ma_a);
      wq_data_a.push_back(md_a);
    end
    if (mw_b && !wait_b) begin
      img_b[ma_b[9:1]] <= md_b;
      wcnt_b <= wcnt_b + 1;
    end
  end

  // Read enable and write request must never coincide.
  always @(negedge clk) begin
    if ((re_a && mw_a) || (re_b && mw_b)) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns in cycle 1 of the frame (FETCH of word 0).
  task automatic start_a(input logic [63:0] b);
    fd_a   = 1'b1;
    base_a = b;
    @(negedge clk);
    fd_a   = 1'b0;
    base_a = 64'hDEAD_0000_0000_0000;
    chk("start_busy", {63'd0, busy_a}, 64'd1);
    chk("start_reen", {63'd0, re_a}, 64'd1);
    chk("start_addr", {62'd0, addr_a}, 64'd0);
  endtask

  // Runs dut_a until frame_done; cyc is the frame_done cycle relative to start.
  task automatic run_a(input int sw, input int sn, input int ew, input bit poke,
                       output int cyc);
    int left, n0, w;
    logic [63:0] ha;
    logic [15:0] hd;
    left = sn;
    n0   = wq_addr_a.size();
    cyc  = 1;
    ha   = 64'd0;
    hd   = 16'd0;
    while (!fdone_a && cyc < 200) begin
      wait_a = 1'b0;
      resp_a = 2'b00;
      w = wq_addr_a.size() - n0;
      if (mw_a) begin
        if (w == sw && left > 0) begin
          if (left == sn) begin
            ha = ma_a;
            hd = md_a;
          end else if (ma_a !== ha || md_a !== hd) begin
            unstable++;
          end
          wait_a = 1'b1;
          left--;
        end
        if (w == ew) resp_a = 2'b10;
      end
      fd_a = poke && (cyc == 5);
      if (poke && cyc == 5) base_a = 64'h5000;
      @(negedge clk);
      cyc++;
    end
    wait_a = 1'b0;
    resp_a = 2'b00;
    fd_a   = poke;
    @(negedge clk);
    fd_a   = 1'b0;
  endtask

  initial begin
    int cyc, n0, bad;
    n_rst = 1'b0;
    fd_a = 1'b0; base_a = 64'd0; wait_a = 1'b0; resp_a = 2'b00;
    fd_b = 1'b0; base_b = 64'd0; wait_b = 1'b0; resp_b = 2'b00;
    for (int i = 0; i < 4; i++) buf_a[i] = 16'h00A0 + 16'(i);
    for (int i = 0; i < 512; i++) buf_b[i] = 16'($urandom);
    repeat (3) @(negedge clk);

    chk("rst_reen", {63'd0, re_a}, 64'd0);
    chk("rst_saddr", {62'd0, addr_a}, 64'd0);
    chk("rst_mw", {63'd0, mw_a}, 64'd0);
    chk("rst_maddr", ma_a, 64'd0);
    chk("rst_mdata", {48'd0, md_a}, 64'd0);
    chk("rst_busy", {63'd0, busy_a}, 64'd0);
    chk("rst_fdone", {63'd0, fdone_a}, 64'd0);
    chk("rst_err", {63'd0, err_a}, 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // T2: clean 4-word frame at 0x1000
    n0 = wq_addr_a.size();
    start_a(64'h1000);
    run_a(-1, 0, -1, 1'b0, cyc);
    chk("t2_latency", 64'(cyc), 64'd13);
    chk("t2_nwrites", 64'(wq_addr_a.size() - n0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", wq_addr_a[n0+i], 64'h1000 + 64'(2*i));
      chk("t2_data", {48'd0, wq_data_a[n0+i]}, {48'd0, 16'h00A0 + 16'(i)});
    end
    chk("t2_err", {63'd0, err_a}, 64'd0);
    chk("t2_idle", {63'd0, busy_a}, 64'd0);

    // T3: five wait states on word 1
    n0 = wq_addr_a.size();
    start_a(64'h2000);
    run_a(1, 5, -1, 1'b0, cyc);
    chk("t3_latency", 64'(cyc), 64'd18);
    chk("t3_nwrites", 64'(wq_addr_a.size() - n0), 64'd4);
    chk("t3_stable", 64'(unstable), 64'd0);
    chk("t3_addr1", wq_addr_a[n0+1], 64'h2002);
    chk("t3_data1", {48'd0, wq_data_a[n0+1]}, 64'h00A1);

    // T4: SLVERR on word 2 aborts the frame
    n0 = wq_addr_a.size();
    start_a(64'h3000);
    run_a(-1, 0, 2, 1'b0, cyc);
    chk("t4_latency", 64'(cyc), 64'd10);
    chk("t4_nwrites", 64'(wq_addr_a.size() - n0), 64'd3);
    chk("t4_err", {63'd0, err_a}, 64'd1);
    chk("t4_idle", {63'd0, busy_a}, 64'd0);

    // T5: error cleared on start, address wrap, ignored fft_done pulses
    n0 = wq_addr_a.size();
    start_a(64'hFFFF_FFFF_FFFF_FFFE);
    chk("t5_err_clr", {63'd0, err_a}, 64'd0);
    run_a(-1, 0, -1, 1'b1, cyc);
    chk("t5_latency", 64'(cyc), 64'd13);
    chk("t5_nwrites", 64'(wq_addr_a.size() - n0), 64'd4);
    chk("t5_addr0", wq_addr_a[n0], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t5_addr1", wq_addr_a[n0+1], 64'h0);
    chk("t5_addr3", wq_addr_a[n0+3], 64'h4);
    chk("t5_fin_busy", {63'd0, busy_a}, 64'd0);
    chk("t5_fin_reen", {63'd0, re_a}, 64'd0);
    @(negedge clk);
    chk("t5_still_idle", {63'd0, busy_a}, 64'd0);

    // T1: reset asserted while a write is stalled
    n0 = wq_addr_a.size();
    start_a(64'h4000);
    wait_a = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_in_write", {63'd0, mw_a}, 64'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("t1_mw", {63'd0, mw_a}, 64'd0);
    chk("t1_maddr", ma_a, 64'd0);
    chk("t1_mdata", {48'd0, md_a}, 64'd0);
    chk("t1_busy", {63'd0, busy_a}, 64'd0);
    @(negedge clk);
    n_rst  = 1'b1;
    wait_a = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (fdone_a || busy_a || re_a || mw_a) bad++;
    end
    chk("t1_idle_after", 64'(bad), 64'd0);
    chk("t1_nwrites", 64'(wq_addr_a.size() - n0), 64'd0);

    // T6: 512-point frame with random wait states
    fd_b = 1'b1;
    @(negedge clk);
    fd_b = 1'b0;
    cyc = 1;
    while (!fdone_b && cyc < 20000) begin
      wait_b = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    wait_b = 1'b0;
    chk("t6_done", {63'd0, fdone_b}, 64'd1);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 512; i++) if (img_b[i] !== buf_b[i]) bad++;
    chk("t6_image", 64'(bad), 64'd0);
    chk("t6_nwrites", 64'(wcnt_b), 64'd512);
    chk("t6_nreads", 64'(recnt_b), 64'd512);
    chk("t6_err", {63'd0, err_b}, 64'd0);
    chk("no_overlap", 64'(overlap), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
